// File: rtl/bmu_req_issuer.sv
// rtl/bmu_req_issuer.sv - BMU request issuer with opcode encode, capture pipeline and credit-protected response FIFO
module bmu_req_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             bmu_valid,
  output logic [31:0]      bmu_a,
  output logic [31:0]      bmu_b,
  output logic [22:0]      bmu_ap,
  input  logic [31:0]      bmu_result,
  input  logic             bmu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      err_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // BMU control vector bit positions
  localparam int B_ZBB    = 20;
  localparam int B_LAND   = 16;
  localparam int B_LXOR   = 15;
  localparam int B_SLL    = 14;
  localparam int B_SRA    = 13;
  localparam int B_BEXT   = 11;
  localparam int B_ADD    = 9;
  localparam int B_SLT    = 8;
  localparam int B_UNSIGN = 7;
  localparam int B_SUB    = 6;
  localparam int B_CLZ    = 5;
  localparam int B_MIN    = 2;

  logic [22:0]      ap_enc;
  logic             accept;
  logic             s1_valid;
  logic             s2_valid;
  logic [TAG_W-1:0] s1_tag;
  logic [TAG_W-1:0] s2_tag;
  logic [31:0]      mem_result [DEPTH];
  logic             mem_error  [DEPTH];
  logic [TAG_W-1:0] mem_tag    [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [SW-1:0]    credit_used;

  // Every accepted request owns a FIFO slot from acceptance until it is consumed,
  // so the FIFO write driven by s2 always finds room.
  assign credit_used = SW'(count) + SW'(s1_valid) + SW'(s2_valid);
  assign req_ready   = credit_used < SW'(DEPTH);
  assign accept      = req_valid && req_ready;

  assign fifo_wr   = s2_valid;
  assign rsp_valid = (count != '0);
  assign fifo_rd   = rsp_valid && rsp_ready;

  // Head entry is forced to zero while empty so idle outputs match reset values
  assign rsp_result = rsp_valid ? mem_result[rd_ptr] : 32'd0;
  assign rsp_error  = rsp_valid ? mem_error[rd_ptr]  : 1'b0;
  assign rsp_tag    = rsp_valid ? mem_tag[rd_ptr]    : '0;

  // Opcode to BMU control vector; unused opcodes issue an all-zero vector
  always_comb begin
    ap_enc = '0;
    case (req_op)
      4'd0:  ap_enc[B_ADD]  = 1'b1;
      4'd1:  ap_enc[B_SUB]  = 1'b1;
      4'd2:  ap_enc[B_LAND] = 1'b1;
      4'd3: begin
        ap_enc[B_LAND] = 1'b1;
        ap_enc[B_ZBB]  = 1'b1;
      end
      4'd4:  ap_enc[B_LXOR] = 1'b1;
      4'd5:  ap_enc[B_SLL]  = 1'b1;
      4'd6:  ap_enc[B_SRA]  = 1'b1;
      4'd7:  ap_enc[B_BEXT] = 1'b1;
      4'd8:  ap_enc[B_SLT]  = 1'b1;
      4'd9: begin
        ap_enc[B_SLT]    = 1'b1;
        ap_enc[B_UNSIGN] = 1'b1;
      end
      4'd10: ap_enc[B_MIN]  = 1'b1;
      4'd11: ap_enc[B_CLZ]  = 1'b1;
      default: ap_enc = '0;
    endcase
  end

  // Issue register: BMU inputs carry the accepted request for exactly one cycle, else zero
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bmu_valid <= 1'b0;
      bmu_a     <= 32'd0;
      bmu_b     <= 32'd0;
      bmu_ap    <= 23'd0;
    end else if (accept) begin
      bmu_valid <= 1'b1;
      bmu_a     <= req_a;
      bmu_b     <= req_b;
      bmu_ap    <= ap_enc;
    end else begin
      bmu_valid <= 1'b0;
      bmu_a     <= 32'd0;
      bmu_b     <= 32'd0;
      bmu_ap    <= 23'd0;
    end
  end

  // In-flight tracker: s2 lines up with the cycle the BMU result register is valid
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_tag   <= '0;
    end else begin
      s1_valid <= accept;
      s1_tag   <= accept ? req_tag : '0;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
    end
  end

  // FIFO storage; contents are don't-care until written, outputs are gated by rsp_valid
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_result[wr_ptr] <= bmu_result;
      mem_error[wr_ptr]  <= bmu_error;
      mem_tag[wr_ptr]    <= s2_tag;
    end
  end

  // FIFO pointers and occupancy; simultaneous read and write leaves count unchanged
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of consumed error responses
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      err_cnt <= 16'd0;
    end else if (fifo_rd && rsp_error && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_l)
    !(fifo_wr && (count == FULL_CNT) && !fifo_rd));

endmodule

// File: tb/tb_bmu_req_issuer.sv
// tb/tb_bmu_req_issuer.sv - scoreboard bench for bmu_req_issuer with a behavioural BMU
module tb_bmu_req_issuer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_op = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             bmu_valid;
  logic [31:0]      bmu_a;
  logic [31:0]      bmu_b;
  logic [22:0]      bmu_ap;
  logic [31:0]      bmu_result;
  logic             bmu_error;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic             rsp_error;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      err_cnt;

  always #5 clk = ~clk;

  bmu_req_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .bmu_valid(bmu_valid), .bmu_a(bmu_a), .bmu_b(bmu_b), .bmu_ap(bmu_ap),
    .bmu_result(bmu_result), .bmu_error(bmu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag), .err_cnt(err_cnt)
  );

  // Behavioural BMU: registered result one cycle after valid_in
  function automatic logic [32:0] bmu_calc(input logic [22:0] ap, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    int          n;
    logic        found;
    r = 32'd0;
    e = 1'b0;
    if (ap[9]) begin
      r = a + b;
      e = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (ap[6]) begin
      r = a - b;
      e = (a[31] != b[31]) && (r[31] != a[31]);
    end else if (ap[16]) r = ap[20] ? (a & ~b) : (a & b);
    else if (ap[15]) r = a ^ b;
    else if (ap[14]) r = a << b[4:0];
    else if (ap[13]) r = $unsigned($signed(a) >>> b[4:0]);
    else if (ap[11]) r = {31'd0, a[b[4:0]]};
    else if (ap[8])  r = ap[7] ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
    else if (ap[2])  r = ($signed(a) < $signed(b)) ? a : b;
    else if (ap[5]) begin
      n = 0;
      found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
        if (!found) begin
          if (a[i]) found = 1'b1;
          else n++;
        end
      end
      r = 32'(n);
    end else begin
      r = 32'd0;
      e = 1'b1;
    end
    return {e, r};
  endfunction

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) {bmu_error, bmu_result} <= 33'd0;
    else if (bmu_valid) {bmu_error, bmu_result} <= bmu_calc(bmu_ap, bmu_a, bmu_b);
    else {bmu_error, bmu_result} <= 33'd0;
  end

  typedef struct packed {
    logic [31:0]      res;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  typedef struct packed {
    logic [22:0] ap;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [22:0] ap;
    logic [31:0] res;
    logic        err;
  } vec_t;

  rsp_t exp_q[$];
  iss_t iss_q[$];
  vec_t vecs[$];

  int compared = 0;
  int mismatched = 0;
  int n_rsp = 0;
  logic hold_pending = 1'b0;
  rsp_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Issue monitor: BMU inputs must match the accepted request, and be zero when idle
  always @(negedge clk) begin
    if (rst_l) begin
      if (bmu_valid) begin
        if (iss_q.size() == 0) note_fail("unexpected_issue");
        else begin
          iss_t e;
          e = iss_q.pop_front();
          chk("bmu_ap", 64'(bmu_ap), 64'(e.ap));
          chk("bmu_a", 64'(bmu_a), 64'(e.a));
          chk("bmu_b", 64'(bmu_b), 64'(e.b));
        end
      end else begin
        chk("idle_bmu_inputs", 64'(bmu_a | bmu_b | 32'(bmu_ap)), 64'd0);
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks hold while stalled
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_l) begin
        if (hold_pending) begin
          chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
          chk("rsp_hold_data", 64'({rsp_result, rsp_error, rsp_tag}), 64'(held));
        end
        hold_pending = 1'b0;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) note_fail("unexpected_rsp");
          else begin
            e = exp_q.pop_front();
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
            chk("rsp_error", 64'(rsp_error), 64'(e.err));
            chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            n_rsp++;
          end
        end else if (rsp_valid) begin
          hold_pending = 1'b1;
          held = {rsp_result, rsp_error, rsp_tag};
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [22:0] ap,
                      input logic [31:0] res, input logic err, output int stalls);
    stalls = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_tag = tag;
    while (!req_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!req_ready) begin
      note_fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back('{res: res, err: err, tag: tag});
    iss_q.push_back('{ap: ap, a: a, b: b});
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || iss_q.size() != 0) note_fail(name);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int st;
    int lat;
    int accepted;
    int stall_sum;
    int rsp_base;
    logic rdy;

    vecs.push_back('{op: 4'd0,  a: 32'd5,          b: 32'd7,          ap: 23'h000200, res: 32'd12,         err: 1'b0});
    vecs.push_back('{op: 4'd0,  a: 32'h7FFFFFFF,   b: 32'd1,          ap: 23'h000200, res: 32'h80000000,   err: 1'b1});
    vecs.push_back('{op: 4'd1,  a: 32'd10,         b: 32'd3,          ap: 23'h000040, res: 32'd7,          err: 1'b0});
    vecs.push_back('{op: 4'd2,  a: 32'hF0F01234,   b: 32'h0FF0FF00,   ap: 23'h010000, res: 32'h00F01200,   err: 1'b0});
    vecs.push_back('{op: 4'd3,  a: 32'hFF00FF00,   b: 32'h0F0F0F0F,   ap: 23'h110000, res: 32'hF000F000,   err: 1'b0});
    vecs.push_back('{op: 4'd4,  a: 32'hAAAA5555,   b: 32'hFFFF0000,   ap: 23'h008000, res: 32'h55555555,   err: 1'b0});
    vecs.push_back('{op: 4'd5,  a: 32'd1,          b: 32'd4,          ap: 23'h004000, res: 32'd16,         err: 1'b0});
    vecs.push_back('{op: 4'd6,  a: 32'h80000000,   b: 32'd4,          ap: 23'h002000, res: 32'hF8000000,   err: 1'b0});
    vecs.push_back('{op: 4'd7,  a: 32'h00000010,   b: 32'd4,          ap: 23'h000800, res: 32'd1,          err: 1'b0});
    vecs.push_back('{op: 4'd8,  a: 32'hFFFFFFFF,   b: 32'd1,          ap: 23'h000100, res: 32'd1,          err: 1'b0});
    vecs.push_back('{op: 4'd9,  a: 32'hFFFFFFFF,   b: 32'd1,          ap: 23'h000180, res: 32'd0,          err: 1'b0});
    vecs.push_back('{op: 4'd10, a: 32'hFFFFFFFF,   b: 32'd1,          ap: 23'h000004, res: 32'hFFFFFFFF,   err: 1'b0});
    vecs.push_back('{op: 4'd11, a: 32'h00010000,   b: 32'd0,          ap: 23'h000020, res: 32'd15,         err: 1'b0});
    vecs.push_back('{op: 4'd13, a: 32'h12345678,   b: 32'h9ABCDEF0,   ap: 23'h000000, res: 32'd0,          err: 1'b1});

    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_bmu_valid", 64'(bmu_valid), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_fields", 64'({rsp_result, rsp_error, rsp_tag}), 64'd0);
    chk("reset_err_cnt", 64'(err_cnt), 64'd0);

    // Single ADD: latency from accept edge to visible rsp_valid
    rsp_ready = 1'b1;
    send(vecs[0].op, vecs[0].a, vecs[0].b, TAG_W'(3), vecs[0].ap, vecs[0].res, vecs[0].err, st);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("add_latency", 64'(lat), 64'd3);
    drain("drain_single");

    // Remaining opcode vectors back to back
    for (int i = 1; i < 14; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i), vecs[i].ap, vecs[i].res, vecs[i].err, st);
    end
    drain("drain_vectors");
    chk("err_cnt_after_vectors", 64'(err_cnt), 64'd2);

    // Backpressure: only DEPTH requests may be outstanding
    rsp_base = n_rsp;
    rsp_ready = 1'b0;
    accepted = 0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1;
      req_op = 4'd0;
      req_a = 32'(accepted);
      req_b = 32'd100;
      req_tag = TAG_W'(accepted);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back('{res: 32'(accepted) + 32'd100, err: 1'b0, tag: TAG_W'(accepted)});
        iss_q.push_back('{ap: 23'h000200, a: 32'(accepted), b: 32'd100});
        accepted++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_accepted", 64'(accepted), 64'd4);
    chk("bp_req_ready_low", 64'(req_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    send(4'd0, 32'd4, 32'd100, TAG_W'(4), 23'h000200, 32'd104, 1'b0, st);
    send(4'd0, 32'd5, 32'd100, TAG_W'(5), 23'h000200, 32'd105, 1'b0, st);
    drain("drain_backpressure");
    chk("bp_rsp_count", 64'(n_rsp - rsp_base), 64'd6);

    // Sustained throughput with the consumer always ready
    stall_sum = 0;
    for (int i = 0; i < 8; i++) begin
      send(4'd0, 32'(i), 32'(3 * i), TAG_W'(i + 8), 23'h000200, 32'(4 * i), 1'b0, st);
      stall_sum += st;
    end
    chk("throughput_stalls", 64'(stall_sum), 64'd0);
    drain("drain_throughput");
    chk("err_cnt_before_reset", 64'(err_cnt), 64'd2);

    // Reset with one entry queued and two in flight
    rsp_ready = 1'b0;
    send(4'd0, 32'd1, 32'd1, TAG_W'(1), 23'h000200, 32'd2, 1'b0, st);
    send(4'd0, 32'd2, 32'd2, TAG_W'(2), 23'h000200, 32'd4, 1'b0, st);
    send(4'd0, 32'd3, 32'd3, TAG_W'(3), 23'h000200, 32'd6, 1'b0, st);
    @(negedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    exp_q.delete();
    iss_q.delete();
    hold_pending = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_bmu_valid", 64'(bmu_valid), 64'd0);
    chk("rst_bmu_ap", 64'(bmu_ap), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_fields", 64'({rsp_result, rsp_error, rsp_tag}), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_l = 1'b1;
    rsp_ready = 1'b1;
    rsp_base = n_rsp;
    repeat (6) @(negedge clk);
    chk("no_stale_rsp", 64'(n_rsp - rsp_base), 64'd0);
    send(4'd0, 32'd1, 32'd2, TAG_W'(9), 23'h000200, 32'd3, 1'b0, st);
    drain("drain_after_reset");
    chk("post_reset_rsp_count", 64'(n_rsp - rsp_base), 64'd1);
    chk("total_rsp_count", 64'(n_rsp), 64'd29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
